// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter that shares one non-stallable pipelined MAC between R
// requesters. It grants a whole vector at a time, routes results back in grant
// order through a tag FIFO, and buffers them in a credit-limited result FIFO.
module mac_rr_arbiter #(
    parameter int T     = 16,
    parameter int R     = 2,
    parameter int VEC_S = 8,
    parameter int D     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*T-1:0]   req_a,
    input  logic [R*T-1:0]   req_b,
    input  logic [R*T-1:0]   req_x,
    output logic [T-1:0]     mac_a,
    output logic [T-1:0]     mac_b,
    output logic [T-1:0]     mac_x,
    output logic             mac_valid_in,
    input  logic [T-1:0]     mac_f,
    input  logic             mac_valid_out,
    output logic [R-1:0]     rsp_valid,
    output logic [T-1:0]     rsp_data,
    input  logic [R-1:0]     rsp_ready,
    output logic             busy,
    output logic             err
);

    localparam int TW = $clog2(R);
    localparam int BW = (VEC_S > 1) ? $clog2(VEC_S) : 1;
    localparam int OW = $clog2(D + 1);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic int rr_index(input int base, input int k);
        int s;
        s = base + k;
        if (s >= R) s = s - R;
        return s;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t          state_q, state_d;
    logic [TW-1:0]   g_q, g_d;
    logic [TW-1:0]   rr_q, rr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [OW-1:0]   out_q, out_d;
    logic            err_q;
    logic [T-1:0]    hold_a_q, hold_b_q, hold_x_q;

    logic [TW-1:0]   tag_mem [D];
    logic [PW-1:0]   tag_wr_q, tag_rd_q;
    logic [OW-1:0]   tag_cnt_q;

    logic [TW-1:0]   res_tag_mem [D];
    logic [T-1:0]    res_data_mem [D];
    logic [PW-1:0]   res_wr_q, res_rd_q;
    logic [OW-1:0]   res_cnt_q;

    logic [T-1:0]    a_lane [R];
    logic [T-1:0]    b_lane [R];
    logic [T-1:0]    x_lane [R];

    logic            grant;
    logic [TW-1:0]   grant_idx;
    logic [TW-1:0]   cand;
    logic            beat_acc;
    logic            last_beat;
    logic            tag_pop;
    logic            res_nonempty;
    logic [TW-1:0]   res_head_tag;
    logic            res_pop;

    // Unpack the per-requester operand buses into lanes
    always_comb begin
        for (int i = 0; i < R; i++) begin
            a_lane[i] = req_a[i*T +: T];
            b_lane[i] = req_b[i*T +: T];
            x_lane[i] = req_x[i*T +: T];
        end
    end

    // Cyclic search from rr_q for the next requester to grant while credits remain
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < R; k++) begin
            cand = TW'(rr_index(int'(rr_q), k));
            if (!grant && req_valid[cand]) begin
                grant     = 1'b1;
                grant_idx = cand;
            end
        end
        if (state_q != IDLE || out_q >= OW'(D)) grant = 1'b0;
    end

    assign beat_acc     = (state_q == STREAM) && req_valid[g_q];
    assign last_beat    = beat_acc && (beat_q == BW'(VEC_S - 1));
    assign tag_pop      = mac_valid_out && (tag_cnt_q != '0);
    assign res_nonempty = (res_cnt_q != '0);
    assign res_head_tag = res_tag_mem[res_rd_q];
    assign res_pop      = res_nonempty && rsp_ready[res_head_tag];

    // Next-state logic: grant in IDLE, count accepted beats in STREAM
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    g_d     = grant_idx;
                    beat_d  = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    state_d = IDLE;
                    beat_d  = '0;
                    rr_d    = (g_q == TW'(R - 1)) ? '0 : g_q + 1'b1;
                end else if (beat_acc) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit counter: one credit per granted vector, returned on result pop
    always_comb begin
        out_d = out_q;
        case ({grant, res_pop})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    // Requester handshake and MAC drive; data holds its last value outside STREAM
    always_comb begin
        req_ready    = '0;
        mac_a        = hold_a_q;
        mac_b        = hold_b_q;
        mac_x        = hold_x_q;
        mac_valid_in = beat_acc;
        if (state_q == STREAM) begin
            req_ready[g_q] = 1'b1;
            mac_a          = a_lane[g_q];
            mac_b          = b_lane[g_q];
            mac_x          = x_lane[g_q];
        end
    end

    // Present the result FIFO head to its owner only
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (res_nonempty) begin
            rsp_valid[res_head_tag] = 1'b1;
            rsp_data                = res_data_mem[res_rd_q];
        end
    end

    assign busy = (state_q == STREAM) || (out_q != '0);
    assign err  = err_q;

    // Control state, FIFO pointers/counts and MAC hold registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            g_q       <= '0;
            rr_q      <= '0;
            beat_q    <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
            hold_x_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            out_q   <= out_d;
            if (mac_valid_out && tag_cnt_q == '0) err_q <= 1'b1;
            if (grant)   tag_wr_q <= ptr_inc(tag_wr_q);
            if (tag_pop) tag_rd_q <= ptr_inc(tag_rd_q);
            case ({grant, tag_pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
            if (tag_pop) res_wr_q <= ptr_inc(res_wr_q);
            if (res_pop) res_rd_q <= ptr_inc(res_rd_q);
            case ({tag_pop, res_pop})
                2'b10:   res_cnt_q <= res_cnt_q + 1'b1;
                2'b01:   res_cnt_q <= res_cnt_q - 1'b1;
                default: res_cnt_q <= res_cnt_q;
            endcase
            if (state_q == STREAM) begin
                hold_a_q <= mac_a;
                hold_b_q <= mac_b;
                hold_x_q <= mac_x;
            end
        end
    end

    // FIFO storage; validity is tracked by the pointers and counts above
    always_ff @(posedge clk) begin
        if (grant) tag_mem[tag_wr_q] <= grant_idx;
        if (tag_pop) begin
            res_tag_mem[res_wr_q]  <= tag_mem[tag_rd_q];
            res_data_mem[res_wr_q] <= mac_f;
        end
    end

endmodule
